// File: rtl/flash_page_prog_seq_if.sv
// Handshake bundle between the page-program sequencer and its surroundings:
// the host-side start/status signals and the request/ack pairs towards the
// write-enable command engine, the burst writer and the status-poll engine.
interface flash_page_prog_seq_if #(
    parameter int PNUM_W = 16
);
    // Host side
    logic              start;
    logic [23:0]       start_addr;
    logic [PNUM_W-1:0] page_num;
    logic              busy;
    logic              done;
    logic              error;
    logic [PNUM_W-1:0] pages_left;

    // Write-enable (06h) command engine
    logic              wren_req;
    logic              wren_ack;

    // Page-program burst writer
    logic              burst_start;
    logic [23:0]       burst_addr;
    logic              burst_finish;

    // Read-status (05h) engine
    logic              rdsr_req;
    logic              rdsr_done;
    logic [7:0]        rdsr_status;

    // Environment side: drives start and the engine acknowledgements
    modport master (
        output start, start_addr, page_num,
        output wren_ack, burst_finish, rdsr_done, rdsr_status,
        input  busy, done, error, pages_left,
        input  wren_req, burst_start, burst_addr, rdsr_req
    );

    // Sequencer side
    modport slave (
        input  start, start_addr, page_num,
        input  wren_ack, burst_finish, rdsr_done, rdsr_status,
        output busy, done, error, pages_left,
        output wren_req, burst_start, burst_addr, rdsr_req
    );
endinterface

// File: rtl/flash_page_prog_seq.sv
// Multi-page SPI flash program sequencer. For every page it requests a
// Write-Enable, launches one page-program burst, then polls the status
// register (with an idle gap between polls) until Write-In-Progress clears.
// The page address advances by PAGE_BYTES (wrapping in the 24-bit space)
// until the requested number of pages has been written. A page whose WIP
// bit never clears within POLL_MAX polls aborts the whole sequence.
// Every output is a flop; request pulses are derived from the next state so
// they appear in the same cycle the FSM enters the corresponding state.
module flash_page_prog_seq #(
    parameter int PNUM_W     = 16,
    parameter int PAGE_BYTES = 256,
    parameter int POLL_GAP   = 64,
    parameter int POLL_MAX   = 4096,
    parameter int WIP_BIT    = 0
) (
    input  logic                 clock,
    input  logic                 rst,
    flash_page_prog_seq_if.slave bus
);

    localparam int PCNT_W = $clog2(POLL_MAX + 1);
    localparam int GCNT_W = $clog2(POLL_GAP + 1);

    typedef enum logic [3:0] {
        IDLE,
        WREN,
        WREN_WAIT,
        BURST,
        BURST_WAIT,
        POLL,
        POLL_WAIT,
        GAP,
        NEXT,
        DONE,
        ERR
    } state_t;

    state_t              state_q, state_d;
    logic [PNUM_W-1:0]   pages_left_q, pages_left_d;
    logic [23:0]         burst_addr_q, burst_addr_d;
    logic [PCNT_W-1:0]   poll_cnt_q, poll_cnt_d;
    logic [GCNT_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                wren_req_q, wren_req_d;
    logic                burst_start_q, burst_start_d;
    logic                rdsr_req_q, rdsr_req_d;

    logic                start_ok;
    logic                wip;

    // busy_q is low exactly in IDLE, DONE and ERR, so a start arriving on the
    // done/error cycle is accepted just like one arriving in IDLE.
    assign start_ok = bus.start & ~busy_q;
    assign wip      = bus.rdsr_status[WIP_BIT];

    // Next-state, page bookkeeping and poll/gap counters.
    always_comb begin
        state_d      = state_q;
        pages_left_d = pages_left_q;
        burst_addr_d = burst_addr_q;
        poll_cnt_d   = poll_cnt_q;
        gap_cnt_d    = gap_cnt_q;

        unique case (state_q)
            IDLE, DONE, ERR: begin
                state_d = IDLE;
                if (start_ok) begin
                    pages_left_d = bus.page_num;
                    burst_addr_d = bus.start_addr;
                    if (bus.page_num != '0) begin
                        state_d = WREN;
                    end else begin
                        // Nothing to program: report completion straight away.
                        state_d = DONE;
                    end
                end
            end

            WREN: begin
                state_d = WREN_WAIT;
            end

            WREN_WAIT: begin
                if (bus.wren_ack) begin
                    state_d = BURST;
                end
            end

            BURST: begin
                state_d = BURST_WAIT;
            end

            BURST_WAIT: begin
                if (bus.burst_finish) begin
                    state_d    = POLL;
                    poll_cnt_d = '0;
                end
            end

            POLL: begin
                state_d    = POLL_WAIT;
                poll_cnt_d = poll_cnt_q + 1'b1;
            end

            POLL_WAIT: begin
                if (bus.rdsr_done) begin
                    if (!wip) begin
                        state_d = NEXT;
                    end else if (poll_cnt_q == PCNT_W'(POLL_MAX)) begin
                        state_d = ERR;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end
                end
            end

            GAP: begin
                if (gap_cnt_q == GCNT_W'(POLL_GAP - 1)) begin
                    state_d = POLL;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            NEXT: begin
                // The address simply wraps in the 24-bit space.
                pages_left_d = pages_left_q - 1'b1;
                burst_addr_d = burst_addr_q + 24'(PAGE_BYTES);
                if (pages_left_q == PNUM_W'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = WREN;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs follow the state being entered on this edge.
    always_comb begin
        wren_req_d    = (state_d == WREN);
        burst_start_d = (state_d == BURST);
        rdsr_req_d    = (state_d == POLL);
        done_d        = (state_d == DONE);
        error_d       = (state_d == ERR);
        busy_d        = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERR));
    end

    // FSM state register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Page count, page address and poll/gap counters.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pages_left_q <= '0;
            burst_addr_q <= '0;
            poll_cnt_q   <= '0;
            gap_cnt_q    <= '0;
        end else begin
            pages_left_q <= pages_left_d;
            burst_addr_q <= burst_addr_d;
            poll_cnt_q   <= poll_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    // Status flags and request pulses.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            wren_req_q    <= 1'b0;
            burst_start_q <= 1'b0;
            rdsr_req_q    <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            wren_req_q    <= wren_req_d;
            burst_start_q <= burst_start_d;
            rdsr_req_q    <= rdsr_req_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.pages_left  = pages_left_q;
    assign bus.wren_req    = wren_req_q;
    assign bus.burst_start = burst_start_q;
    assign bus.burst_addr  = burst_addr_q;
    assign bus.rdsr_req    = rdsr_req_q;

endmodule

// File: tb/tb_flash_page_prog_seq.sv
// Bench for flash_page_prog_seq: a responder answers every request after a
// fixed delay and logs what the sequencer did; a table of whole-sequence
// scenarios is run and compared, followed by hand-written sequences for
// start-while-busy and reset in the middle of a page.
module tb_flash_page_prog_seq;

    localparam int GAP     = 4;
    localparam int PMAX    = 4;
    localparam int ACK_DLY = 2;

    logic clock;
    logic rst;

    flash_page_prog_seq_if #(.PNUM_W(16)) ifc ();

    flash_page_prog_seq #(
        .PNUM_W    (16),
        .PAGE_BYTES(256),
        .POLL_GAP  (GAP),
        .POLL_MAX  (PMAX),
        .WIP_BIT   (0)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Responder configuration (written by the main sequence only)
    int cfg_wip;
    bit cfg_stuck;
    bit cfg_spur;

    // Observation state (written by the responder only)
    int          cyc;
    int          n_wren, n_burst, n_rdsr, n_done, n_err, busy_cyc;
    int          gap_bad, lat_bad;
    logic [23:0] addr_log [64];
    int          pl_log   [64];
    int          wren_cyc_log [64];
    int          end_cyc_log  [64];
    int          n_end;

    // Scoreboard counters
    int n_vec;
    int n_bad;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Responder and monitor, evaluated 1 time unit after each rising edge.
    initial begin : bfm
        int wren_cd, burst_cd, rdsr_cd, poll_idx, clear_cyc, last_rdsr;
        wren_cd = 0; burst_cd = 0; rdsr_cd = 0; poll_idx = 0;
        clear_cyc = -1; last_rdsr = -1;
        cyc = 0; n_wren = 0; n_burst = 0; n_rdsr = 0; n_done = 0; n_err = 0;
        busy_cyc = 0; gap_bad = 0; lat_bad = 0; n_end = 0;
        ifc.wren_ack = 1'b0; ifc.burst_finish = 1'b0;
        ifc.rdsr_done = 1'b0; ifc.rdsr_status = 8'hFF;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            ifc.wren_ack     = 1'b0;
            ifc.burst_finish = 1'b0;
            ifc.rdsr_done    = 1'b0;
            ifc.rdsr_status  = 8'hFF;
            if (rst) begin
                wren_cd = 0; burst_cd = 0; rdsr_cd = 0;
                clear_cyc = -1; last_rdsr = -1;
            end else begin
                if (wren_cd > 0) begin
                    wren_cd--;
                    if (wren_cd == 0) begin
                        ifc.wren_ack = 1'b1;
                        if (cfg_spur) begin
                            ifc.burst_finish = 1'b1;
                            ifc.rdsr_done    = 1'b1;
                            ifc.rdsr_status  = 8'hFE;
                        end
                    end
                end
                if (burst_cd > 0) begin
                    burst_cd--;
                    if (burst_cd == 0) ifc.burst_finish = 1'b1;
                end
                if (rdsr_cd > 0) begin
                    rdsr_cd--;
                    if (rdsr_cd == 0) begin
                        poll_idx++;
                        ifc.rdsr_done = 1'b1;
                        if (cfg_stuck || poll_idx <= cfg_wip) begin
                            ifc.rdsr_status = 8'h03;
                        end else begin
                            ifc.rdsr_status = 8'hFE;
                            clear_cyc = cyc;
                        end
                    end
                end
                if (ifc.wren_req) begin
                    wren_cyc_log[n_wren & 63] = cyc;
                    if (clear_cyc >= 0 && cyc - clear_cyc != 2) lat_bad++;
                    clear_cyc = -1;
                    n_wren++;
                    wren_cd = ACK_DLY;
                end
                if (ifc.burst_start) begin
                    addr_log[n_burst & 63] = ifc.burst_addr;
                    pl_log[n_burst & 63]   = int'(ifc.pages_left);
                    n_burst++;
                    poll_idx  = 0;
                    last_rdsr = -1;
                    burst_cd  = ACK_DLY;
                end
                if (ifc.rdsr_req) begin
                    if (last_rdsr >= 0 && cyc - last_rdsr != ACK_DLY + GAP + 1) gap_bad++;
                    last_rdsr = cyc;
                    n_rdsr++;
                    rdsr_cd = ACK_DLY;
                end
            end
            if (ifc.done) begin
                end_cyc_log[n_end & 63] = cyc;
                n_end++;
                n_done++;
                clear_cyc = -1;
            end
            if (ifc.error) begin
                end_cyc_log[n_end & 63] = cyc;
                n_end++;
                n_err++;
            end
            if (ifc.busy) busy_cyc++;
        end
    end

    typedef struct {
        logic [23:0] addr;
        int          pn;
        int          wip;
        bit          stuck;
        bit          spur;
        int          e_wren;
        int          e_burst;
        int          e_rdsr;
        int          e_done;
        int          e_err;
        logic [23:0] a0;
        logic [23:0] a1;
        logic [23:0] a2;
        int          e_pl_end;
    } vec_t;

    vec_t tbl [6];

    int start_cyc;

    task automatic pulse_start(input logic [23:0] addr, input int pn);
        @(negedge clock);
        ifc.start      = 1'b1;
        ifc.start_addr = addr;
        ifc.page_num   = 16'(pn);
        start_cyc      = cyc;
        @(negedge clock);
        ifc.start = 1'b0;
    endtask

    task automatic wait_end(input int bd, input int be, input string name);
        int k;
        k = 0;
        while (n_done == bd && n_err == be && k < 3000) begin
            @(negedge clock);
            k++;
        end
        check({name, "_finished"}, (n_done != bd || n_err != be), 1);
    endtask

    initial begin : main
        int b_wren, b_burst, b_rdsr, b_done, b_err, b_busy, b_gap, b_lat, b_end;
        logic [23:0] exp_a;
        int t;
        string nm;

        n_vec = 0; n_bad = 0;
        cfg_wip = 0; cfg_stuck = 1'b0; cfg_spur = 1'b0;
        rst = 1'b1;
        ifc.start = 1'b0; ifc.start_addr = '0; ifc.page_num = '0;

        //           addr        pn wip stk spr wren brst rdsr done err  a0          a1          a2        pl_end
        tbl[0] = '{24'h001000, 1, 0, 1'b0, 1'b0, 1, 1, 1, 1, 0, 24'h001000, 24'h000000, 24'h000000, 0};
        tbl[1] = '{24'h000200, 3, 2, 1'b0, 1'b0, 3, 3, 9, 1, 0, 24'h000200, 24'h000300, 24'h000400, 0};
        tbl[2] = '{24'hFFFF00, 2, 0, 1'b0, 1'b0, 2, 2, 2, 1, 0, 24'hFFFF00, 24'h000000, 24'h000000, 0};
        tbl[3] = '{24'h010000, 3, 0, 1'b1, 1'b0, 1, 1, 4, 0, 1, 24'h010000, 24'h000000, 24'h000000, 3};
        tbl[4] = '{24'h123400, 0, 0, 1'b0, 1'b0, 0, 0, 0, 1, 0, 24'h000000, 24'h000000, 24'h000000, 0};
        tbl[5] = '{24'h000000, 2, 1, 1'b0, 1'b1, 2, 2, 4, 1, 0, 24'h000000, 24'h000100, 24'h000000, 0};

        repeat (3) @(negedge clock);
        check("reset_outputs",
              {ifc.busy, ifc.done, ifc.error, ifc.wren_req, ifc.burst_start,
               ifc.rdsr_req, ifc.pages_left, ifc.burst_addr}, 0);
        @(negedge clock);
        rst = 1'b0;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            nm = $sformatf("row%0d", i);
            b_wren = n_wren; b_burst = n_burst; b_rdsr = n_rdsr; b_done = n_done;
            b_err = n_err; b_busy = busy_cyc; b_gap = gap_bad; b_lat = lat_bad; b_end = n_end;
            cfg_wip = tbl[i].wip; cfg_stuck = tbl[i].stuck; cfg_spur = tbl[i].spur;
            pulse_start(tbl[i].addr, tbl[i].pn);
            wait_end(b_done, b_err, nm);
            repeat (8) @(negedge clock);

            check({nm, "_wren"},  n_wren  - b_wren,  tbl[i].e_wren);
            check({nm, "_burst"}, n_burst - b_burst, tbl[i].e_burst);
            check({nm, "_rdsr"},  n_rdsr  - b_rdsr,  tbl[i].e_rdsr);
            check({nm, "_done"},  n_done  - b_done,  tbl[i].e_done);
            check({nm, "_error"}, n_err   - b_err,   tbl[i].e_err);
            check({nm, "_pages_left_end"}, ifc.pages_left, tbl[i].e_pl_end);
            check({nm, "_busy_end"}, ifc.busy, 0);
            check({nm, "_poll_gap"}, gap_bad - b_gap, 0);
            check({nm, "_next_wren_lat"}, lat_bad - b_lat, 0);
            for (int p = 0; p < tbl[i].e_burst && p < 3; p++) begin
                exp_a = (p == 0) ? tbl[i].a0 : (p == 1) ? tbl[i].a1 : tbl[i].a2;
                check($sformatf("%s_addr%0d", nm, p), addr_log[(b_burst + p) & 63], exp_a);
                check($sformatf("%s_pages_left%0d", nm, p), pl_log[(b_burst + p) & 63], tbl[i].pn - p);
            end
            if (tbl[i].pn == 0) begin
                t = end_cyc_log[b_end & 63];
                check({nm, "_done_lat"}, t - start_cyc, 1);
                check({nm, "_busy_cycles"}, busy_cyc - b_busy, 0);
            end else begin
                t = wren_cyc_log[b_wren & 63];
                check({nm, "_wren_lat"}, t - start_cyc, 1);
                check({nm, "_busy_cycles"}, busy_cyc - b_busy,
                      end_cyc_log[b_end & 63] - (start_cyc + 1));
            end
        end
        cfg_wip = 0; cfg_stuck = 1'b0; cfg_spur = 1'b0;

        // Start while busy must be ignored.
        b_burst = n_burst; b_done = n_done; b_err = n_err;
        pulse_start(24'h002000, 2);
        t = 0;
        while (n_burst == b_burst && t < 200) begin
            @(negedge clock);
            t++;
        end
        pulse_start(24'h777700, 7);
        @(negedge clock);
        check("busy_start_pages_left", ifc.pages_left, 2);
        check("busy_start_addr", ifc.burst_addr, 24'h002000);
        wait_end(b_done, b_err, "busy_start");
        repeat (8) @(negedge clock);
        check("busy_start_bursts", n_burst - b_burst, 2);
        check("busy_start_addr1", addr_log[(b_burst + 1) & 63], 24'h002100);
        check("busy_start_done", n_done - b_done, 1);

        // Reset while waiting for the burst writer.
        b_burst = n_burst; b_done = n_done; b_err = n_err;
        pulse_start(24'h003000, 2);
        t = 0;
        while (n_burst == b_burst && t < 200) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        rst = 1'b1;
        #1;
        check("midrst_outputs",
              {ifc.busy, ifc.done, ifc.error, ifc.wren_req, ifc.burst_start,
               ifc.rdsr_req, ifc.pages_left, ifc.burst_addr}, 0);
        @(negedge clock);
        rst = 1'b0;
        repeat (20) @(negedge clock);
        check("midrst_no_done_err", (n_done - b_done) + (n_err - b_err), 0);
        check("midrst_idle_busy", ifc.busy, 0);

        b_burst = n_burst; b_done = n_done; b_err = n_err;
        pulse_start(24'h004000, 1);
        wait_end(b_done, b_err, "after_rst");
        repeat (8) @(negedge clock);
        check("after_rst_done", n_done - b_done, 1);
        check("after_rst_bursts", n_burst - b_burst, 1);
        check("after_rst_addr", addr_log[b_burst & 63], 24'h004000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
